// File: rtl/al_buckeye_readback.sv
// Buckeye chain readback: oversamples SDO on the shift clock, packs bits LSB-first into
// 16-bit words and queues them in a 512x16 FIFO. Define AL_RBK_CRC_EN to add the session CRC-16.
module al_buckeye_readback (
   input  logic        CLK40,
   input  logic        RST,
   input  logic        CLK1MHZ,
   input  logic        SHCK_ENA,
   input  logic        SDO,
   input  logic        AL_BKY_ENA,
   input  logic        CLR_RBK_DONE,
   input  logic        RBK_FIFO_RST,
   input  logic        RD_EN,
   output logic [15:0] DOUT,
   output logic        RD_VALID,
   output logic        EMPTY,
   output logic        FULL,
   output logic [9:0]  WORD_CNT,
   output logic        OVFL,
   output logic        PARTIAL,
   output logic        RBK_DONE,
   output logic [15:0] CRC
);

   typedef enum logic [1:0] {IDLE, SHIFT, FLUSH, DONE} state_t;

   logic [3:0]  async_in;
   logic [3:0]  meta_reg, sync_reg;
   logic        clk_d_reg, bky_d_reg;
   logic        sdo_s, strobe, bky_rise, bky_fall, shift_strobe, session_start;
   state_t      state_reg, state_next;
   logic [3:0]  cnt_reg, cnt_next;
   logic [15:0] sreg_reg, sreg_next;
   logic        partial_reg, partial_next;
   logic        push_reg, push_next;
   logic [15:0] push_data_reg, push_data_next;
   logic [15:0] mem [0:511];
   logic [8:0]  wr_ptr_reg, rd_ptr_reg;
   logic [9:0]  count_reg;
   logic        wr_en, rd_acc;

   // bit order: 0 shift clock, 1 shift enable, 2 data, 3 session enable
   assign async_in = {AL_BKY_ENA, SDO, SHCK_ENA, CLK1MHZ};

   always_ff @(posedge CLK40 or posedge RST) begin
      if (RST) begin
         meta_reg  <= '0;
         sync_reg  <= '0;
         clk_d_reg <= 1'b0;
         bky_d_reg <= 1'b0;
      end else begin
         meta_reg  <= async_in;
         sync_reg  <= meta_reg;
         clk_d_reg <= sync_reg[0];
         bky_d_reg <= sync_reg[3];
      end
   end

   assign sdo_s        = sync_reg[2];
   assign strobe       = sync_reg[0] & ~clk_d_reg & sync_reg[1];
   assign bky_rise     = sync_reg[3] & ~bky_d_reg;
   assign bky_fall     = ~sync_reg[3] & bky_d_reg;
   assign shift_strobe = (state_reg == SHIFT) && strobe;

   always_ff @(posedge CLK40 or posedge RST) begin
      if (RST) begin
         state_reg     <= IDLE;
         cnt_reg       <= '0;
         sreg_reg      <= '0;
         partial_reg   <= 1'b0;
         push_reg      <= 1'b0;
         push_data_reg <= '0;
      end else begin
         state_reg     <= state_next;
         cnt_reg       <= cnt_next;
         sreg_reg      <= sreg_next;
         partial_reg   <= partial_next;
         push_reg      <= push_next;
         push_data_reg <= push_data_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      cnt_next       = cnt_reg;
      sreg_next      = sreg_reg;
      partial_next   = partial_reg;
      push_next      = 1'b0;
      push_data_next = push_data_reg;
      session_start  = 1'b0;
      case (state_reg)
         IDLE:  session_start = bky_rise;
         SHIFT: begin
            if (strobe) begin
               sreg_next = {sdo_s, sreg_reg[15:1]};
               cnt_next  = cnt_reg + 4'd1;
               if (cnt_reg == 4'd15) begin
                  push_next      = 1'b1;
                  push_data_next = {sdo_s, sreg_reg[15:1]};
               end
            end
            // a strobe coinciding with the falling edge is still captured above
            if (bky_fall)
               state_next = FLUSH;
         end
         FLUSH: begin
            if (cnt_reg != 4'd0) begin
               push_next      = 1'b1;
               push_data_next = sreg_reg >> (5'd16 - {1'b0, cnt_reg});
               partial_next   = 1'b1;
            end
            state_next = DONE;
         end
         DONE: begin
            if (bky_rise)
               session_start = 1'b1;
            else if (CLR_RBK_DONE)
               state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
      if (session_start) begin
         cnt_next     = '0;
         sreg_next    = '0;
         partial_next = 1'b0;
         state_next   = SHIFT;
      end
   end

   assign PARTIAL  = partial_reg;
   assign RBK_DONE = (state_reg == DONE);

`ifdef AL_RBK_CRC_EN
   logic [15:0] crc_reg;
   logic        crc_fb;
   assign crc_fb = crc_reg[15] ^ sdo_s;

   always_ff @(posedge CLK40 or posedge RST) begin
      if (RST)
         crc_reg <= 16'hFFFF;
      else if (session_start)
         crc_reg <= 16'hFFFF;
      else if (shift_strobe)
         crc_reg <= {crc_reg[14:0], 1'b0} ^ (crc_fb ? 16'h1021 : 16'h0000);
   end
   assign CRC = crc_reg;
`else
   assign CRC = 16'h0000;
`endif

   // a push coinciding with the FIFO clear is discarded along with the contents
   assign wr_en  = push_reg & ~FULL & ~RBK_FIFO_RST;
   assign rd_acc = RD_EN & ~EMPTY & ~RBK_FIFO_RST;

   always_ff @(posedge CLK40) begin
      if (wr_en)
         mem[wr_ptr_reg] <= push_data_reg;
   end

   always_ff @(posedge CLK40 or posedge RST) begin
      if (RST) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
         OVFL       <= 1'b0;
         RD_VALID   <= 1'b0;
         DOUT       <= '0;
      end else if (RBK_FIFO_RST) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
         OVFL       <= 1'b0;
         RD_VALID   <= 1'b0;
      end else begin
         if (wr_en)
            wr_ptr_reg <= wr_ptr_reg + 9'd1;
         if (rd_acc) begin
            rd_ptr_reg <= rd_ptr_reg + 9'd1;
            DOUT       <= mem[rd_ptr_reg];
         end
         if (push_reg && FULL)
            OVFL <= 1'b1;
         RD_VALID  <= rd_acc;
         count_reg <= count_reg + {9'd0, wr_en} - {9'd0, rd_acc};
      end
   end

   assign WORD_CNT = count_reg;
   assign EMPTY    = (count_reg == 10'd0);
   assign FULL     = (count_reg == 10'd512);

endmodule
